// File: rtl/mux8_32_if.sv
// mux8_32_if -- byte-in / word-out bus for the 8-to-32 packer.
//   data_in     [7:0]  input byte, qualified by valid_in
//   valid_in           data_in carries a valid byte this cycle
//   data_out    [31:0] last completed word, held between completions
//   valid_out          one-cycle pulse marking a newly completed word
//   err_timeout        one-cycle pulse on partial-word discard
//                      (present only when MUX8_32_TIMEOUT_EN is defined)
// master: byte producer side; slave: the packer.
interface mux8_32_if;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
`ifdef MUX8_32_TIMEOUT_EN
  logic        err_timeout;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, err_timeout
  );
  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, err_timeout
  );
`else
  modport master (
    output data_in, valid_in,
    input  data_out, valid_out
  );
  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out
  );
`endif
endinterface

// File: rtl/mux8_32.sv
// mux8_32 -- packs four valid bytes into one 32-bit word, MSB first.
// Ports:
//   clk_4f  sole clock, rising edge
//   reset   synchronous, active-high; clears word, partial bytes and pulses
//   bus     mux8_32_if.slave (data_in/valid_in in, data_out/valid_out/err_timeout out)
// Optional feature, macro MUX8_32_TIMEOUT_EN: a partial word that sees four
// consecutive idle cycles is discarded and err_timeout pulses for one cycle.
// Without the macro, partial words are held indefinitely.
module mux8_32 (
  input logic       clk_4f,
  input logic       reset,
  mux8_32_if.slave  bus
);

  // The state encoding is the byte count itself: StIdle = 0, StFill1..3 = 1..3.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill1 = 2'd1,
    StFill2 = 2'd2,
    StFill3 = 2'd3
  } state_t;

  state_t      state_q;
  logic [23:0] partial_q;
  logic [31:0] data_out_q;
  logic        valid_out_q;
`ifdef MUX8_32_TIMEOUT_EN
  logic [2:0]  idle_q;
  logic        err_q;
`endif

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q     <= StIdle;
      partial_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
`ifdef MUX8_32_TIMEOUT_EN
      idle_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      valid_out_q <= 1'b0;
`ifdef MUX8_32_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      if (bus.valid_in) begin
`ifdef MUX8_32_TIMEOUT_EN
        idle_q <= '0;
`endif
        if (state_q == StFill3) begin
          // Earlier bytes sit in partial_q oldest-first, so the word is a concat.
          data_out_q  <= {partial_q, bus.data_in};
          valid_out_q <= 1'b1;
          partial_q   <= '0;
          state_q     <= StIdle;
        end else begin
          partial_q <= {partial_q[15:0], bus.data_in};
          state_q   <= state_t'(state_q + 2'd1);
        end
      end
`ifdef MUX8_32_TIMEOUT_EN
      else if (state_q != StIdle) begin
        // idle_q == 3 means this edge is the fourth idle cycle in a row.
        if (idle_q == 3'd3) begin
          state_q   <= StIdle;
          partial_q <= '0;
          idle_q    <= '0;
          err_q     <= 1'b1;
        end else begin
          idle_q <= idle_q + 3'd1;
        end
      end else begin
        idle_q <= '0;
      end
`endif
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
`ifdef MUX8_32_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`endif

endmodule

// File: tb/tb_mux8_32.sv
// tb_mux8_32 -- self-checking bench for mux8_32: directed vector table,
// timeout / hold sequence, Demux32_8 loopback and randomized traffic against
// a queue-based reference model. Build with MUX8_32_TIMEOUT_EN to cover the
// timeout variant.
module tb_mux8_32;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_4f = ~clk_4f;

  mux8_32_if bus ();

  mux8_32 dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: bytes of the word being assembled, idle run length.
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic ev, input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.exp_valid = ev; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset        = r;
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  // Reference: bytes collect in a queue; four of them make a word.
  task automatic model(input logic r, input logic v, input logic [7:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_bytes.delete();
      m_data = 32'h0;
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      m_bytes.push_back(d);
      if (m_bytes.size() == 4) begin
        m_data  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_valid = 1'b1;
        m_bytes.delete();
      end
    end else if (m_bytes.size() != 0) begin
`ifdef MUX8_32_TIMEOUT_EN
      m_idle++;
      if (m_idle == 4) begin
        m_bytes.delete();
        m_idle = 0;
        m_err  = 1'b1;
      end
`endif
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic err_chk(input string name, input logic exp);
`ifdef MUX8_32_TIMEOUT_EN
    chk(name, {31'b0, bus.err_timeout}, {31'b0, exp});
`else
    if (exp) chk(name, 32'h0, 32'h1);
`endif
  endtask

  // Behavioural Demux32_8: emits a word as four bytes MSB first with short bubbles.
  logic [31:0] sb[$];
  task automatic demux_send(input logic [31:0] w);
    logic [31:0] wv;
    wv = w;
    for (int i = 3; i >= 0; i--) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 1'b0, 8'($urandom));
        if (bus.valid_out) begin
          if (sb.size() == 0) chk("loop_extra", bus.data_out, 32'hx);
          else chk("loop_word", bus.data_out, sb.pop_front());
        end
      end
      step(1'b0, 1'b1, wv[i*8 +: 8]);
      if (bus.valid_out) begin
        if (sb.size() == 0) chk("loop_extra", bus.data_out, 32'hx);
        else chk("loop_word", bus.data_out, sb.pop_front());
      end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    m_idle = 0;
    m_data = 32'h0;

    // AA BB CC DD after two reset cycles
    add(1, 0, 8'hxx, 0, 32'h0);
    add(1, 0, 8'hxx, 0, 32'h0);
    add(0, 1, 8'hAA, 0, 32'h0);
    add(0, 1, 8'hBB, 0, 32'h0);
    add(0, 1, 8'hCC, 0, 32'h0);
    add(0, 1, 8'hDD, 1, 32'hAABBCCDD);
    add(0, 0, 8'hxx, 0, 32'hAABBCCDD);
    // 01..08 streamed back to back
    for (int i = 1; i <= 8; i++) begin
      add(0, 1, 8'(i), (i == 4 || i == 8),
          (i < 4) ? 32'hAABBCCDD : (i < 8) ? 32'h01020304 : 32'h05060708);
    end
    add(0, 0, 8'hxx, 0, 32'h05060708);
    add(0, 0, 8'hxx, 0, 32'h05060708);
    // bubbles between bytes
    add(0, 1, 8'h11, 0, 32'h05060708);
    add(0, 1, 8'h22, 0, 32'h05060708);
    add(0, 0, 8'hxx, 0, 32'h05060708);
    add(0, 0, 8'hxx, 0, 32'h05060708);
    add(0, 1, 8'h33, 0, 32'h05060708);
    add(0, 1, 8'h44, 1, 32'h11223344);
    add(0, 0, 8'hxx, 0, 32'h11223344);
    // reset mid-word discards 55 66; reset wins over valid_in
    add(0, 1, 8'h55, 0, 32'h11223344);
    add(0, 1, 8'h66, 0, 32'h11223344);
    add(1, 1, 8'hEE, 0, 32'h0);
    add(0, 1, 8'h77, 0, 32'h0);
    add(0, 1, 8'h88, 0, 32'h0);
    add(0, 1, 8'h99, 0, 32'h0);
    add(0, 1, 8'hAA, 1, 32'h778899AA);
    add(0, 0, 8'hxx, 0, 32'h778899AA);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.valid_out}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].exp_data);
      err_chk($sformatf("vec%0d_err", i), 1'b0);
    end

    // Partial word followed by a long idle run.
    step(0, 1, 8'hEE);
`ifdef MUX8_32_TIMEOUT_EN
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 8'hxx);
      err_chk($sformatf("to_idle%0d_err", i), (i == 4));
      chk("to_hold_data", bus.data_out, 32'h778899AA);
      chk("to_valid", {31'b0, bus.valid_out}, 32'h0);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 8'(i));
      err_chk("to_after_err", 1'b0);
    end
    chk("to_word_valid", {31'b0, bus.valid_out}, 32'h1);
    chk("to_word_data", bus.data_out, 32'h01020304);
`else
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 8'hxx);
      chk("hold_valid", {31'b0, bus.valid_out}, 32'h0);
    end
    step(0, 1, 8'h02);
    step(0, 1, 8'h03);
    step(0, 1, 8'h04);
    chk("hold_word_valid", {31'b0, bus.valid_out}, 32'h1);
    chk("hold_word_data", bus.data_out, 32'hEE020304);
`endif

    // Demux32_8 loopback
    step(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = $urandom;
      sb.push_back(w);
      demux_send(w);
    end
    step(0, 0, 8'h00);
    chk("loop_drained", 32'(sb.size()), 32'h0);

    // Randomized traffic against the reference model
    step(1, 0, 8'h00);
    model(1, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      logic [7:0] d;
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 9) < 6);
      d = 8'($urandom);
      step(r, v, d);
      model(r, v, d);
      chk("rnd_valid", {31'b0, bus.valid_out}, {31'b0, m_valid});
      chk("rnd_data", bus.data_out, m_data);
      err_chk("rnd_err", m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux8_32.md
MUX8_32 -- requirements
Module: mux8_32

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8-bit input and 32-bit output.
REQ-002 clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_4f.
REQ-004 data_in  input  8  input byte, qualified by valid_in.
REQ-005 valid_in  input  1  data_in carries a valid byte this cycle.
REQ-006 data_out  output  32  assembled word, registered, held until the next completed word.
REQ-007 valid_out  output  1  registered, one-cycle pulse marking a newly completed word on data_out.
REQ-008 err_timeout  output  1  registered, one-cycle pulse on partial-word discard (present only with MUX8_32_TIMEOUT_EN).

Function
REQ-009 The block SHALL pack four valid bytes into one 32-bit word, most significant byte first: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-010 State SHALL be a 2-bit byte counter: IDLE (count 0) and FILL (count 1..3).
REQ-011 A byte SHALL be captured only on an edge where valid_in=1.
REQ-012 Each capture SHALL increment count modulo 4.
REQ-013 valid_in=0 SHALL hold count and partial data unchanged (bubbles tolerated between bytes).
REQ-014 On the edge capturing byte 3, data_out SHALL load the full word and valid_out SHALL be 1 for exactly that following cycle (latency: word visible the cycle after its last byte is sampled).
REQ-015 count SHALL wrap to 0 (IDLE) on that same edge.
REQ-016 Back-to-back valid bytes SHALL yield one valid_out pulse every 4 cycles, with no lost bytes.
REQ-017 data_out SHALL NOT change except on word completion or reset.
REQ-018 Partial words SHALL never appear on data_out.
REQ-019 X on data_in while valid_in=0 SHALL NOT affect any output.

Reset
REQ-020 While reset=1, the block SHALL set data_out=32'h0, valid_out=0, err_timeout=0, count=0, and clear the partial-word register.
REQ-021 Reset SHALL take priority over valid_in on the same edge.
REQ-022 A reset asserted mid-word SHALL discard the bytes already captured.
REQ-023 The first valid byte after reset deasserts SHALL be treated as byte 0.

Configuration
REQ-024 The macro MUX8_32_TIMEOUT_EN SHALL control the partial-word timeout feature.
REQ-025 With MUX8_32_TIMEOUT_EN defined, a 3-bit idle counter SHALL count consecutive valid_in=0 cycles while in FILL.
REQ-026 With the timeout enabled, on the 4th consecutive idle cycle in FILL the block SHALL discard the partial word, set count=0, and pulse err_timeout for one cycle; data_out SHALL be unchanged.
REQ-027 With the timeout enabled, the idle counter SHALL clear on any valid byte, in IDLE, and on reset.
REQ-028 Without MUX8_32_TIMEOUT_EN, the err_timeout port and the idle counter SHALL be absent, and partial words SHALL be held indefinitely.

Verification
REQ-029 Reset 2 cycles, then bytes AA,BB,CC,DD with valid_in=1 on consecutive cycles -> data_out=32'hAABBCCDD and valid_out=1 for one cycle after the DD edge.
REQ-030 Stream 8 consecutive bytes 01..08 -> words 32'h01020304 then 32'h05060708 with valid_out pulses 4 cycles apart; data_out holds 32'h05060708 afterwards.
REQ-031 Bytes 11,22, then valid_in=0 for 2 cycles, then 33,44 -> data_out=32'h11223344 with a single valid_out pulse and no timeout.
REQ-032 Bytes 55,66, assert reset 1 cycle, then 77,88,99,AA -> data_out=32'h778899AA; 55 and 66 never appear on data_out.
REQ-033 Timeout enabled: byte EE, then valid_in=0 for 4 cycles -> err_timeout pulses once, data_out unchanged, and the next 4 bytes 01,02,03,04 -> 32'h01020304.
REQ-034 Compare against the Demux32_8 loopback: Demux32_8 output feeding mux8_32 SHALL reproduce the original 32-bit words in order.
